// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generation stage: imm_type encodings and buffer depth.
package imm_pkg;

    localparam int DEPTH = 2;

    typedef enum logic [3:0] {
        IMM_I   = 4'd0,
        IMM_S   = 4'd1,
        IMM_B   = 4'd2,
        IMM_U   = 4'd3,
        IMM_J   = 4'd4,
        IMM_Z   = 4'd5,
        IMM_SH  = 4'd6,
        IMM_CI  = 4'd8,
        IMM_CSS = 4'd9,
        IMM_CJ  = 4'd10,
        IMM_CB  = 4'd11
    } imm_type_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction/extension for all supported formats.
// Compressed formats are built only when IMM_GEN_RVC_EN is defined.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [3:0]      imm_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [63:0] wide;
    logic [15:0] half;

    assign half = instr[15:0];

`ifndef IMM_GEN_RVC_EN
    // Low opcode bits only matter for compressed formats.
    logic unused_low_bits;
    assign unused_low_bits = ^{instr[6:0]};
`endif

    always_comb begin
        wide    = '0;
        illegal = 1'b0;
        case (imm_type)
            IMM_I:  wide = {{52{instr[31]}}, instr[31:20]};
            IMM_S:  wide = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:  wide = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:  wide = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J:  wide = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_Z:  wide = {59'b0, instr[19:15]};
            IMM_SH: wide = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
`ifdef IMM_GEN_RVC_EN
            IMM_CI:  wide = {{58{half[12]}}, half[12], half[6:2]};
            IMM_CSS: wide = {56'b0, half[8:7], half[12:9], 2'b00};
            IMM_CJ:  wide = {{52{half[12]}}, half[12], half[8], half[10:9], half[6], half[7],
                             half[2], half[11], half[5:3], 1'b0};
            IMM_CB:  wide = {{55{half[12]}}, half[12], half[6:5], half[2], half[11:10],
                             half[4:3], 1'b0};
`endif
            default: begin
                wide    = '0;
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = wide[XLEN-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer on a valid/ready handshake.
// Optional compressed formats are enabled by defining IMM_GEN_RVC_EN.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [3:0]      imm_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      imm_type_o,
    output logic            illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end
    if (DEPTH != imm_pkg::DEPTH) begin : g_bad_depth
        $error("imm_gen_stage: DEPTH must be 2");
    end

    logic [XLEN-1:0] ext_imm;
    logic            ext_illegal;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (instr),
        .imm_type(imm_type),
        .imm     (ext_imm),
        .illegal (ext_illegal)
    );

    logic [XLEN-1:0] imm_mem  [2];
    logic [3:0]      type_mem [2];
    logic            ill_mem  [2];
    logic [1:0]      count;
    logic [1:0]      count_nxt;
    logic            rd_ptr;
    logic            rd_nxt;
    logic            wr_ptr;
    logic            push;
    logic            pop;
    logic            fwd;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count_nxt = count + {1'b0, push} - {1'b0, pop};
    assign rd_nxt    = rd_ptr ^ pop;
    // Head slot being written this very cycle: take the new value directly.
    assign fwd       = push && (wr_ptr == rd_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            imm        <= '0;
            imm_type_o <= 4'd0;
            illegal    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_mem[i]  <= '0;
                type_mem[i] <= 4'd0;
                ill_mem[i]  <= 1'b0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                imm_mem[wr_ptr]  <= ext_imm;
                type_mem[wr_ptr] <= imm_type;
                ill_mem[wr_ptr]  <= ext_illegal;
                wr_ptr           <= ~wr_ptr;
            end
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            // Output registers hold their last value while the buffer is empty.
            if (count_nxt != 2'd0) begin
                imm        <= fwd ? ext_imm     : imm_mem[rd_nxt];
                imm_type_o <= fwd ? imm_type    : type_mem[rd_nxt];
                illegal    <= fwd ? ext_illegal : ill_mem[rd_nxt];
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed, table-driven bench for imm_gen_stage at XLEN=32 and XLEN=64 side by side.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [3:0]  imm_type;
    logic        out_ready;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    logic [3:0]  type32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [3:0]  type64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_type(imm_type), .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .imm_type_o(type32), .illegal(illegal32)
    );

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_type(imm_type), .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .imm_type_o(type64), .illegal(illegal64)
    );

    typedef struct {
        logic [3:0]  t;
        logic [31:0] ins;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] t, input logic [31:0] ins,
                                input logic [31:0] e32, input logic [63:0] e64, input logic ill);
        vec_t v;
        v.t = t; v.ins = ins; v.e32 = e32; v.e64 = e64; v.ill = ill;
        return v;
    endfunction

    // Compressed vectors collapse to imm=0/illegal when the formats are not built.
    function automatic vec_t mk_rvc(input logic [3:0] t, input logic [31:0] ins,
                                    input logic [31:0] e32, input logic [63:0] e64);
`ifdef IMM_GEN_RVC_EN
        return mk(t, ins, e32, e64, 1'b0);
`else
        return mk(t, ins, 32'h0, 64'h0, 1'b1);
`endif
    endfunction

    task automatic push_word(input logic [3:0] t, input logic [31:0] ins);
        in_valid = 1'b1;
        imm_type = t;
        instr    = ins;
    endtask

    initial begin
        vt[0]  = mk(4'd0, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        vt[1]  = mk(4'd0, 32'h7FF00093, 32'h000007FF, 64'h00000000000007FF, 1'b0);
        vt[2]  = mk(4'd1, 32'h00A00223, 32'h00000004, 64'h0000000000000004, 1'b0);
        vt[3]  = mk(4'd2, 32'hFE000FE3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0);
        vt[4]  = mk(4'd3, 32'h123450B7, 32'h12345000, 64'h0000000012345000, 1'b0);
        vt[5]  = mk(4'd3, 32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        vt[6]  = mk(4'd4, 32'h0080006F, 32'h00000008, 64'h0000000000000008, 1'b0);
        vt[7]  = mk(4'd4, 32'h8000006F, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0);
        vt[8]  = mk(4'd5, 32'h000FD073, 32'h0000001F, 64'h000000000000001F, 1'b0);
        vt[9]  = mk(4'd6, 32'h03F01093, 32'h0000001F, 64'h000000000000003F, 1'b0);
        vt[10] = mk(4'd15, 32'hFFFFFFFF, 32'h0, 64'h0, 1'b1);
        vt[11] = mk(4'd7, 32'h12345678, 32'h0, 64'h0, 1'b1);
        vt[12] = mk_rvc(4'd8,  32'h0000107D, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        vt[13] = mk_rvc(4'd9,  32'h00000480, 32'h00000048, 64'h0000000000000048);
        vt[14] = mk_rvc(4'd10, 32'h00001000, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800);
        vt[15] = mk_rvc(4'd11, 32'h0000000C, 32'h00000022, 64'h0000000000000022);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; imm_type = 4'd0;
        step; step;
        chk("rst_out_valid", {63'b0, out_valid32}, 64'd0);
        chk("rst_in_ready",  {63'b0, in_ready32},  64'd1);
        chk("rst_imm32",     {32'b0, imm32},       64'd0);
        chk("rst_imm64",     imm64,                64'd0);
        chk("rst_type",      {60'b0, type32},      64'd0);
        chk("rst_illegal",   {63'b0, illegal32},   64'd0);
        rst_n = 1'b1;
        step;

        for (int i = 0; i < 16; i++) begin
            push_word(vt[i].t, vt[i].ins);
            out_ready = 1'b0;
            step;
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), {63'b0, out_valid32}, 64'd1);
            chk($sformatf("v%0d_imm32", i),     {32'b0, imm32},       {32'b0, vt[i].e32});
            chk($sformatf("v%0d_imm64", i),     imm64,                vt[i].e64);
            chk($sformatf("v%0d_illegal", i),   {63'b0, illegal32},   {63'b0, vt[i].ill});
            chk($sformatf("v%0d_illegal64", i), {63'b0, illegal64},   {63'b0, vt[i].ill});
            chk($sformatf("v%0d_type", i),      {60'b0, type32},      {60'b0, vt[i].t});
            out_ready = 1'b1;
            step;
            out_ready = 1'b0;
            chk($sformatf("v%0d_empty", i),     {63'b0, out_valid32}, 64'd0);
            chk($sformatf("v%0d_hold", i),      {32'b0, imm32},       {32'b0, vt[i].e32});
        end

        // Backpressure: three words with the consumer stalled, then drained.
        push_word(4'd0, 32'h00100093);
        step;
        chk("bp_ready_after1", {63'b0, in_ready32}, 64'd1);
        push_word(4'd0, 32'h00200093);
        step;
        chk("bp_ready_after2", {63'b0, in_ready32}, 64'd0);
        push_word(4'd0, 32'h00300093);
        step;
        chk("bp_ready_held",   {63'b0, in_ready32}, 64'd0);
        chk("bp_head_stable",  {32'b0, imm32},      64'd1);
        out_ready = 1'b1;
        step;
        chk("bp_out1_valid", {63'b0, out_valid32}, 64'd1);
        chk("bp_out1",       {32'b0, imm32},       64'd2);
        step;
        in_valid = 1'b0;
        chk("bp_out2_valid", {63'b0, out_valid32}, 64'd1);
        chk("bp_out2",       {32'b0, imm32},       64'd3);
        step;
        out_ready = 1'b0;
        chk("bp_drained",    {63'b0, out_valid32}, 64'd0);
        chk("bp_ready_end",  {63'b0, in_ready32},  64'd1);

        // Flush with two entries buffered and in_valid raised in the same cycle.
        push_word(4'd0, 32'h00400093);
        step;
        push_word(4'd0, 32'h00500093);
        step;
        push_word(4'd0, 32'h00600093);
        flush = 1'b1;
        step;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl2_out_valid", {63'b0, out_valid32}, 64'd0);
        chk("fl2_in_ready",  {63'b0, in_ready32},  64'd1);
        chk("fl2_hold",      {32'b0, imm32},       64'd4);

        // Flush at one entry where the simultaneous push is actually accepted-eligible.
        push_word(4'd0, 32'h00700093);
        step;
        push_word(4'd0, 32'h00800093);
        flush = 1'b1;
        step;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl1_out_valid", {63'b0, out_valid32}, 64'd0);
        step;
        chk("fl1_no_ghost",  {63'b0, out_valid32}, 64'd0);
        push_word(4'd0, 32'h00900093);
        step;
        in_valid = 1'b0;
        chk("fl1_next_valid", {63'b0, out_valid32}, 64'd1);
        chk("fl1_next_imm",   {32'b0, imm32},       64'd9);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("fl1_next_empty", {63'b0, out_valid32}, 64'd0);

        // Asynchronous reset in the middle of a buffered transfer.
        push_word(4'd2, 32'hFE000FE3);
        step;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'b0, out_valid32}, 64'd0);
        chk("arst_imm64",     imm64,                64'd0);
        chk("arst_type",      {60'b0, type64},      64'd0);
        chk("arst_in_ready",  {63'b0, in_ready64},  64'd1);
        step;
        rst_n = 1'b1;
        step;
        chk("arst_after",     {63'b0, out_valid64}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
